// File: rtl/imem_line_buffer_if.sv
// Line-refill bus between imem_line_buffer and the instruction memory.
// master: buffer (req/addr out), slave: memory (ready/beats out).
interface imem_line_buffer_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_ready,
    input  bus_rvalid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_ready,
    output bus_rvalid,
    output bus_rdata
  );
endinterface

// File: rtl/imem_line_buffer.sv
// Single-line instruction buffer: combinational hits, stalling burst refill.
// Ports: clk, reset (async active-low), mem_addr/flush in, data/stop out,
//        bus (master): bus_req/bus_addr out, bus_ready/bus_rvalid/bus_rdata in.
module imem_line_buffer #(
  parameter int LINE_WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         mem_addr,
  input  logic                flush,
  output logic [31:0]         data,
  output logic                stop,
  imem_line_buffer_if.master  bus
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = 32 - OFF_W;

  localparam logic [31:0]      NOP  = 32'h0000_0013;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } state_t;

  state_t           state;
  logic [31:0]      line_q [LINE_WORDS];
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] pend_q;
  logic             valid_q;
  logic             discard_q;
  logic [IDX_W-1:0] beat_cnt;
  logic             req_q;
  logic [31:0]      addr_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] word_idx;
  logic             hit;
  logic             beat;
  logic             unused_addr_bits;

  assign req_tag  = mem_addr[31:OFF_W];
  assign word_idx = mem_addr[OFF_W-1:2];
  assign unused_addr_bits = ^mem_addr[1:0];

  assign hit  = valid_q && (tag_q == req_tag)
             && (state == IDLE);
  assign beat = (state == FILL) && bus.bus_rvalid;

  assign data = hit ? line_q[word_idx] : NOP;
  // Never stall while held in reset so fetch can reset itself.
  assign stop = reset && !hit;

  assign bus.bus_req  = req_q;
  assign bus.bus_addr = addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
      beat_cnt  <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      tag_q     <= '0;
      pend_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush)
            valid_q <= 1'b0;
          if (!hit) begin
            state  <= REQ;
            req_q  <= 1'b1;
            addr_q <= {req_tag, {OFF_W{1'b0}}};
            pend_q <= req_tag;
          end
        end
        REQ: begin
          if (flush)
            discard_q <= 1'b1;
          if (bus.bus_ready) begin
            req_q    <= 1'b0;
            beat_cnt <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (flush)
            discard_q <= 1'b1;
          if (bus.bus_rvalid) begin
            // Old contents are being overwritten.
            valid_q  <= 1'b0;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST) begin
              state     <= IDLE;
              tag_q     <= pend_q;
              // A flush seen at any point of the burst
              // leaves the freshly filled line invalid.
              valid_q   <= !discard_q && !flush;
              discard_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat)
      line_q[beat_cnt] <= bus.bus_rdata;
  end

endmodule

// File: tb/tb_imem_line_buffer.sv
// Scoreboard bench for imem_line_buffer: directed fetch/refill scenarios.
// Monitor checks every delivered word and every accepted line request.
module tb_imem_line_buffer;

  localparam int          LW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] data;
  logic        stop;

  imem_line_buffer_if bus_if ();

  imem_line_buffer #(.LINE_WORDS(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_addr (mem_addr),
    .flush    (flush),
    .data     (data),
    .stop     (stop),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data [$];
  logic [31:0] exp_req  [$];

  int          mem_wait = 0;
  int          mem_gap  = 0;
  int          m_st = 0;
  int          m_wl = 0;
  int          m_gl = 0;
  int          m_bi = 0;
  logic [31:0] m_base = '0;

  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [11:0] w;
    w = a[13:2];
    return {w, 20'h0} | {20'h0, w[4:0], 7'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] w,
                       output int stall);
    exp_data.push_back(w);
    mem_addr = a;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!stop) break;
      stall++;
      if (stall > 60) begin
        checks++;
        errors++;
        $display("FAIL fetch_timeout %h: stall %0d want <= 60", a, stall);
        break;
      end
    end
    step();
  endtask

  // Backing memory: optional ready wait, then LW beats with gaps.
  initial begin
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = '0;
    forever begin
      step();
      bus_if.bus_ready  = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      if (m_st == 2) begin
        if (m_gl == 0) begin
          bus_if.bus_rvalid = 1'b1;
          bus_if.bus_rdata  = mem_word(m_base + 32'(m_bi * 4));
          m_bi++;
          m_gl = mem_gap;
          if (m_bi == LW) m_st = 0;
        end else begin
          m_gl--;
        end
      end else if (m_st == 0 && bus_if.bus_req) begin
        m_base = bus_if.bus_addr;
        m_wl   = mem_wait;
        m_st   = 1;
      end
      if (m_st == 1) begin
        if (m_wl == 0) begin
          bus_if.bus_ready = 1'b1;
          m_st = 2;
          m_bi = 0;
          m_gl = 0;
        end else begin
          m_wl--;
        end
      end
    end
  end

  // Monitor: deliveries, accepted requests, request hold while waiting.
  always @(negedge clk) begin
    if (reset) begin
      if (prev_pend) begin
        chk("req_held", 32'(bus_if.bus_req), 32'd1);
        chk("addr_held", bus_if.bus_addr, prev_addr);
      end
      if (!stop) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_delivery: got %h at %h want none",
                   data, mem_addr);
        end else begin
          chk("data", data, exp_data.pop_front());
        end
      end
      if (bus_if.bus_req && bus_if.bus_ready) begin
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_request: got %h want none",
                   bus_if.bus_addr);
        end else begin
          chk("bus_addr", bus_if.bus_addr, exp_req.pop_front());
        end
      end
      prev_pend = bus_if.bus_req && !bus_if.bus_ready;
      prev_addr = bus_if.bus_addr;
    end else begin
      prev_pend = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int st;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst_stop", 32'(stop), 32'd0);
    chk("rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_addr", bus_if.bus_addr, 32'h0);
    chk("rst_data", data, NOP);
    step();

    // 1: cold start
    reset = 1'b1;
    exp_req.push_back(32'h0);
    fetch(32'h0, 32'h0000_0013, st);
    chk("t1_stall", 32'(st), 32'd6);
    fetch(32'h4, 32'h0010_0093, st);
    chk("t1_hit4", 32'(st), 32'd0);
    fetch(32'h8, 32'h0020_0113, st);
    chk("t1_hit8", 32'(st), 32'd0);
    fetch(32'hc, 32'h0030_0193, st);
    chk("t1_hitc", 32'(st), 32'd0);

    // 2: line crossing
    exp_req.push_back(32'h10);
    fetch(32'h10, 32'h0040_0213, st);
    chk("t2_stall", 32'(st), 32'd6);

    // 3: memory wait states
    mem_wait = 3;
    mem_gap  = 2;
    exp_req.push_back(32'h20);
    fetch(32'h24, 32'h0090_0493, st);
    chk("t3_stall", 32'(st), 32'd15);
    mem_wait = 0;
    mem_gap  = 0;
    fetch(32'h20, 32'h0080_0413, st);
    chk("t3_hit20", 32'(st), 32'd0);
    fetch(32'h28, 32'h00a0_0513, st);
    fetch(32'h2c, 32'h00b0_0593, st);
    chk("t3_hit2c", 32'(st), 32'd0);

    // 4a: flush during an IDLE hit
    exp_data.push_back(32'h00b0_0593);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_req.push_back(32'h20);
    fetch(32'h2c, 32'h00b0_0593, st);
    chk("t4a_stall", 32'(st), 32'd6);

    // 4b: flush during beat 2
    exp_req.push_back(32'h30);
    exp_req.push_back(32'h30);
    fork
      fetch(32'h30, 32'h00c0_0613, st);
      begin
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
    join
    chk("t4b_stall", 32'(st), 32'd12);
    fetch(32'h3c, 32'h00f0_0793, st);
    chk("t4b_hit3c", 32'(st), 32'd0);

    // 6: address change during FILL
    exp_req.push_back(32'h40);
    exp_req.push_back(32'h50);
    fork
      fetch(32'h40, 32'h0150_0a93, st);
      begin
        repeat (3) step();
        mem_addr = 32'h54;
      end
    join
    chk("t6_stall", 32'(st), 32'd12);
    fetch(32'h50, 32'h0140_0a13, st);
    chk("t6_hit50", 32'(st), 32'd0);

    // 5: reset mid-burst (after beat 1), beats keep coming
    exp_req.push_back(32'h60);
    exp_req.push_back(32'h60);
    mem_addr = 32'h60;
    repeat (4) step();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_stop", 32'(stop), 32'd0);
    chk("t5_req", 32'(bus_if.bus_req), 32'd0);
    chk("t5_addr", bus_if.bus_addr, 32'h0);
    chk("t5_data", data, NOP);
    step();
    reset = 1'b1;
    fetch(32'h60, 32'h0180_0c13, st);
    chk("t5_stall", 32'(st), 32'd6);

    // Wind down on a miss so no further words are delivered.
    exp_req.push_back(32'h1000);
    mem_addr = 32'h1000;
    repeat (3) step();
    chk("data_q_empty", 32'(exp_data.size()), 32'd0);
    chk("req_q_empty", 32'(exp_req.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
